ex_pipe_skid_reg: RTL

- Parametrised EX→MEM pipeline stage register that replaces the fixed stall/flush register with a valid/ready handshake and a 2-entry skid buffer, giving full throughput without a combinational ready path.
- Adds N-source prioritised exception injection: the excepting beat is neutralised, while its PC and branch flag are kept for the exception unit.
- Sits between the ALU and the MEM stage; upstream is ID/EX plus the ALU, downstream is MEM.

---
 rtl/ex_pipe_skid_reg.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ex_pipe_skid_reg.sv
// EX->MEM pipeline register: valid/ready handshake with a 2-entry skid buffer and
// prioritised exception injection. Optional counters under `EX_PIPE_PERF_EN`.
module ex_pipe_skid_reg #(
    parameter int unsigned               PC_W    = 30,
    parameter int unsigned               DATA_W  = 64,
    parameter logic [DATA_W-1:0]         NOP_VAL = '0,
    parameter int unsigned               EXP_W   = 3,
    parameter int unsigned               EXC_N   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [PC_W-1:0]          up_pc,
    input  logic                     up_br_flag,
    input  logic [DATA_W-1:0]        up_payload,
    input  logic [EXP_W-1:0]         up_exp_code,
    input  logic [EXC_N-1:0]         exc_req,
    input  logic [EXC_N*EXP_W-1:0]   exc_code,
    input  logic                     flush,
    output logic                     dn_valid,
    input  logic                     dn_ready,
    output logic [PC_W-1:0]          dn_pc,
    output logic                     dn_br_flag,
    output logic [DATA_W-1:0]        dn_payload,
    output logic [EXP_W-1:0]         dn_exp_code
`ifdef EX_PIPE_PERF_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              kill_cnt
`endif
);

    // Beat layout: {pc, br_flag, payload, exp_code}
    localparam int unsigned BEAT_W = PC_W + 1 + DATA_W + EXP_W;
    localparam logic [BEAT_W-1:0] BEAT_CLR = {{PC_W{1'b0}}, 1'b0, NOP_VAL, {EXP_W{1'b0}}};

    logic              r_m_valid;
    logic              r_s_valid;
    logic [BEAT_W-1:0] r_m_beat;
    logic [BEAT_W-1:0] r_s_beat;
    logic              r_up_ready;

    logic              w_accept;
    logic              w_pop;
    logic [EXP_W-1:0]  w_in_exp;
    logic [BEAT_W-1:0] w_in_beat;
    logic              w_m_valid_nxt;
    logic              w_s_valid_nxt;
    logic [BEAT_W-1:0] w_m_beat_nxt;
    logic [BEAT_W-1:0] w_s_beat_nxt;

    assign w_accept = up_valid && r_up_ready;
    assign w_pop    = r_m_valid && dn_ready;

    // Existing code wins; otherwise lowest-index request wins (descending loop overwrites).
    always_comb begin
        w_in_exp = up_exp_code;
        if (up_exp_code == '0) begin
            for (int i = EXC_N - 1; i >= 0; i--) begin
                if (exc_req[i]) begin
                    w_in_exp = exc_code[i*EXP_W +: EXP_W];
                end
            end
        end
    end

    assign w_in_beat = {up_pc, up_br_flag,
                        (w_in_exp != '0) ? NOP_VAL : up_payload,
                        w_in_exp};

    // Next-state for main/skid entries.
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_s_valid_nxt = r_s_valid;
        w_m_beat_nxt  = r_m_beat;
        w_s_beat_nxt  = r_s_beat;
        if (flush) begin
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
            w_m_beat_nxt  = BEAT_CLR;
            w_s_beat_nxt  = BEAT_CLR;
        end else if (w_pop) begin
            if (r_s_valid) begin
                w_m_valid_nxt = 1'b1;
                w_m_beat_nxt  = r_s_beat;
                w_s_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_m_beat_nxt  = w_in_beat;
            end else begin
                w_m_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            if (!r_m_valid) begin
                w_m_valid_nxt = 1'b1;
                w_m_beat_nxt  = w_in_beat;
            end else begin
                w_s_valid_nxt = 1'b1;
                w_s_beat_nxt  = w_in_beat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_m_beat   <= BEAT_CLR;
            r_s_beat   <= BEAT_CLR;
            r_up_ready <= 1'b1;
        end else begin
            r_m_valid  <= w_m_valid_nxt;
            r_s_valid  <= w_s_valid_nxt;
            r_m_beat   <= w_m_beat_nxt;
            r_s_beat   <= w_s_beat_nxt;
            r_up_ready <= !w_s_valid_nxt;
        end
    end

    assign up_ready    = r_up_ready;
    assign dn_valid    = r_m_valid;
    assign dn_pc       = r_m_beat[BEAT_W-1 -: PC_W];
    assign dn_br_flag  = r_m_beat[DATA_W+EXP_W];
    assign dn_payload  = r_m_beat[EXP_W +: DATA_W];
    assign dn_exp_code = r_m_beat[EXP_W-1:0];

`ifdef EX_PIPE_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_kill_cnt;
    logic [1:0]  w_kill_inc;
    logic [16:0] w_kill_sum;

    assign w_kill_inc = 2'(r_m_valid) + 2'(r_s_valid) + 2'(w_accept);
    assign w_kill_sum = 17'(r_kill_cnt) + 17'(w_kill_inc);

    // Saturating stall and flush-kill counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_kill_cnt  <= '0;
        end else begin
            if (r_m_valid && !dn_ready && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (flush) begin
                r_kill_cnt <= w_kill_sum[16] ? 16'hFFFF : w_kill_sum[15:0];
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign kill_cnt  = r_kill_cnt;
`endif

endmodule
